credential_checker: RTL and testbench

Consumes the 32-word credential stream produced by the ROM memory stage and decides whether a user-entered ID/password pair is authorised to play. On a check request it latches the entered credentials, pulses `Start` to the ROM stage, and compares every (ID, password) record in the stream. It reports grant/deny and locks the game out after three consecutive failed attempts. It sits between the keypad/entry logic and the ROM memory stage.

---
 rtl/credential_checker.sv | 237 +++++++++++++++++++++++
 tb/tb_credential_checker.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/credential_checker.sv
`default_nettype none
// ============================================================================
// Module   : credential_checker
// Purpose  : Checks an entered ID/password pair against the 32-word record
//            stream from the ROM memory stage. Every word is consumed before
//            a result is posted, so check time does not depend on where (or
//            whether) a match occurs. Three consecutive failures lock the
//            game out until reset.
// Ports    : Clk, Reset (async, active-low)
//            Check, UserID, UserPass      - check request from entry logic
//            WordIn, WordValid            - record stream from ROM stage
//            Start                        - one-cycle stream request to ROM
//            Busy, Done                   - check in progress / result pulse
//            Granted, Denied, TimedOut    - held result flags
//            Locked, FailCount            - lockout state
// Revision : 1.0 - initial release
// ============================================================================
module credential_checker #(
    parameter int NUM_WORDS = 32,
    parameter int TIMEOUT   = 64,
    parameter int MAX_FAILS = 3
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Check,
    input  logic [31:0] UserID,
    input  logic [31:0] UserPass,
    input  logic [31:0] WordIn,
    input  logic        WordValid,
    output logic        Start,
    output logic        Busy,
    output logic        Done,
    output logic        Granted,
    output logic        Denied,
    output logic        TimedOut,
    output logic        Locked,
    output logic [1:0]  FailCount
);

    localparam int CNT_W  = $clog2(NUM_WORDS);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0]  c_LAST_WORD   = CNT_W'(NUM_WORDS - 1);
    localparam logic [IDLE_W-1:0] c_TIMEOUT_CNT = IDLE_W'(TIMEOUT);
    localparam logic [1:0]        c_MAX_FAILS   = 2'(MAX_FAILS);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_REQ    = 3'd1;
    localparam logic [2:0] c_STREAM = 3'd2;
    localparam logic [2:0] c_POST   = 3'd3;
    localparam logic [2:0] c_LOCK   = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [31:0]       user_id_q, user_id_d;
    logic [31:0]       user_pass_q, user_pass_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic              id_hit_q, id_hit_d;
    logic              match_q, match_d;
    logic              granted_q, granted_d;
    logic              denied_q, denied_d;
    logic              timed_out_q, timed_out_d;
    logic              locked_q, locked_d;
    logic [1:0]        fail_cnt_q, fail_cnt_d;

    logic              w_word_accept;
    logic              w_id_match;
    logic              w_pass_match;
    logic              w_last_word;
    logic              w_timeout;
    logic              w_final_match;
    logic [IDLE_W-1:0] w_idle_next;
    logic [1:0]        w_fail_next;

    // ------------------------------------------------------------------
    // Stream decode
    // ------------------------------------------------------------------
    always_comb begin
        w_word_accept = (state_q == c_STREAM) && WordValid;
        // ID 0 marks an empty slot and must never match.
        w_id_match    = (WordIn == user_id_q) && (WordIn != 32'd0);
        w_pass_match  = id_hit_q && (WordIn == user_pass_q);
        w_last_word   = w_word_accept && (word_cnt_q == c_LAST_WORD);
        w_idle_next   = idle_cnt_q + IDLE_W'(1);
        // Fires on the TIMEOUT-th consecutive idle cycle, so the result is
        // posted on the following cycle.
        w_timeout     = (state_q == c_STREAM) && !WordValid &&
                        (w_idle_next == c_TIMEOUT_CNT);
        // The last word is a password word; fold its comparison in so the
        // result can be registered on the same edge that consumes it.
        w_final_match = match_q | (w_word_accept && word_cnt_q[0] && w_pass_match);
        w_fail_next   = (fail_cnt_q == 2'd3) ? 2'd3 : fail_cnt_q + 2'd1;
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:   if (Check && !locked_q) state_d = c_REQ;
            c_REQ:    state_d = c_STREAM;
            c_STREAM: if (w_last_word || w_timeout) state_d = c_POST;
            c_POST:   state_d = locked_q ? c_LOCK : c_IDLE;
            c_LOCK:   state_d = c_LOCK;
            default:  state_d = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        Start     = (state_q == c_REQ);
        Busy      = (state_q == c_REQ) || (state_q == c_STREAM) || (state_q == c_POST);
        Done      = (state_q == c_POST);
        Granted   = granted_q;
        Denied    = denied_q;
        TimedOut  = timed_out_q;
        Locked    = locked_q;
        FailCount = fail_cnt_q;
    end

    // ------------------------------------------------------------------
    // Datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        user_id_d   = user_id_q;
        user_pass_d = user_pass_q;
        word_cnt_d  = word_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        id_hit_d    = id_hit_q;
        match_d     = match_q;
        granted_d   = granted_q;
        denied_d    = denied_q;
        timed_out_d = timed_out_q;
        locked_d    = locked_q;
        fail_cnt_d  = fail_cnt_q;

        case (state_q)
            c_IDLE: begin
                if (Check && !locked_q) begin
                    user_id_d   = UserID;
                    user_pass_d = UserPass;
                    granted_d   = 1'b0;
                    denied_d    = 1'b0;
                    timed_out_d = 1'b0;
                    id_hit_d    = 1'b0;
                    match_d     = 1'b0;
                end
            end

            c_REQ: begin
                word_cnt_d = '0;
                idle_cnt_d = '0;
            end

            c_STREAM: begin
                if (WordValid) begin
                    idle_cnt_d = '0;
                    if (!word_cnt_q[0]) begin
                        id_hit_d = w_id_match;
                    end else if (w_pass_match) begin
                        match_d = 1'b1;
                    end
                    word_cnt_d = word_cnt_q + CNT_W'(1);
                end else begin
                    idle_cnt_d = w_idle_next;
                end

                // Result flags are registered on the edge into POST so they
                // are visible together with Done.
                if (w_last_word || w_timeout) begin
                    if (w_timeout) begin
                        timed_out_d = 1'b1;
                    end
                    if (!w_timeout && w_final_match) begin
                        granted_d  = 1'b1;
                        fail_cnt_d = 2'd0;
                    end else begin
                        denied_d   = 1'b1;
                        fail_cnt_d = w_fail_next;
                        if (w_fail_next == c_MAX_FAILS) begin
                            locked_d = 1'b1;
                        end
                    end
                end
            end

            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            user_id_q   <= '0;
            user_pass_q <= '0;
            word_cnt_q  <= '0;
            idle_cnt_q  <= '0;
            id_hit_q    <= 1'b0;
            match_q     <= 1'b0;
            granted_q   <= 1'b0;
            denied_q    <= 1'b0;
            timed_out_q <= 1'b0;
            locked_q    <= 1'b0;
            fail_cnt_q  <= 2'd0;
        end else begin
            user_id_q   <= user_id_d;
            user_pass_q <= user_pass_d;
            word_cnt_q  <= word_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            id_hit_q    <= id_hit_d;
            match_q     <= match_d;
            granted_q   <= granted_d;
            denied_q    <= denied_d;
            timed_out_q <= timed_out_d;
            locked_q    <= locked_d;
            fail_cnt_q  <= fail_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_credential_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_credential_checker
// Purpose  : Self-checking bench for credential_checker. A table of directed
//            checks against a fixed ROM image, hand-written lockout / reset /
//            held-Check sequences, then randomized ROM images and entries
//            compared against a record-search reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_credential_checker;

    logic        Clk;
    logic        Reset;
    logic        Check;
    logic [31:0] UserID;
    logic [31:0] UserPass;
    logic [31:0] WordIn;
    logic        WordValid;
    logic        Start;
    logic        Busy;
    logic        Done;
    logic        Granted;
    logic        Denied;
    logic        TimedOut;
    logic        Locked;
    logic [1:0]  FailCount;

    credential_checker #(
        .NUM_WORDS(32),
        .TIMEOUT  (64),
        .MAX_FAILS(3)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Check    (Check),
        .UserID   (UserID),
        .UserPass (UserPass),
        .WordIn   (WordIn),
        .WordValid(WordValid),
        .Start    (Start),
        .Busy     (Busy),
        .Done     (Done),
        .Granted  (Granted),
        .Denied   (Denied),
        .TimedOut (TimedOut),
        .Locked   (Locked),
        .FailCount(FailCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic [31:0] rom [32];
    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [31:0] id;
        logic [31:0] pw;
        int          gap_max;
        int          n_words;
        logic        g;
        logic        d;
        logic        t;
        logic        l;
        logic [1:0]  fc;
        int          lat;   // -1: latency not checked
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic do_reset();
        Reset = 1'b0; Check = 1'b0; WordValid = 1'b0; WordIn = '0;
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
    endtask

    function automatic void load_fixed_rom();
        for (int k = 0; k < 16; k++) begin
            rom[2*k]   = 32'h0100_0000 + k;
            rom[2*k+1] = 32'h5A5A_0000 + k;
        end
        rom[4]  = 32'hAAAA_0002; rom[5]  = 32'h2222_2222;
        rom[6]  = 32'hBBBB_0003; rom[7]  = 32'h3333_3333;
        rom[10] = 32'h0000_1234; rom[11] = 32'hCAFE_F00D;
        rom[14] = 32'h0000_0000; rom[15] = 32'h7777_7777;
        rom[30] = 32'hF00D_000F; rom[31] = 32'hFFFF_000F;
    endfunction

    // Reference: authorised iff some record has a non-zero ID equal to the
    // entered ID and its password equal to the entered password.
    function automatic bit model_grant(input logic [31:0] id, input logic [31:0] pw);
        for (int k = 0; k < 16; k++)
            if (id != 0 && rom[2*k] == id && rom[2*k+1] == pw) return 1'b1;
        return 1'b0;
    endfunction

    // Issue one check and stream rom[0..n_words-1]. Cycle 0 is the Check
    // cycle; lat is the cycle index of Done. A word is also offered in the
    // Start cycle and must be ignored. reset_at >= 0 asserts Reset just
    // before that word index and returns with Reset still low.
    task automatic do_check(input logic [31:0] id, input logic [31:0] pw,
                            input int gap_max, input int n_words,
                            input int reset_at, input bit hold,
                            output bit done, output int lat, output bit hs_ok);
        int c, w, gap;
        done = 1'b0; lat = -1; hs_ok = 1'b1;
        @(negedge Clk);
        if (Busy !== 1'b0 || Start !== 1'b0) hs_ok = 1'b0;
        UserID = id; UserPass = pw; Check = 1'b1; WordValid = 1'b0;
        @(negedge Clk); c = 1;
        if (Start !== 1'b1 || Busy !== 1'b1 || Done !== 1'b0) hs_ok = 1'b0;
        if (!hold) Check = 1'b0;
        WordValid = 1'b1; WordIn = rom[0];
        w = 0;
        gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
        while (!done && c < 400) begin
            @(negedge Clk); c++;
            if (Start !== 1'b0 || Busy !== 1'b1) hs_ok = 1'b0;
            if (Done === 1'b1) begin
                done = 1'b1; lat = c;
            end else if (reset_at >= 0 && w == reset_at) begin
                Reset = 1'b0; WordValid = 1'b0; Check = 1'b0;
                #1;
                return;
            end else if (w < n_words) begin
                if (gap > 0) begin
                    WordValid = 1'b0; gap--;
                end else begin
                    WordValid = 1'b1; WordIn = rom[w]; w++;
                    gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
                end
            end else begin
                WordValid = 1'b0;
            end
        end
        WordValid = 1'b0;
        if (!hold) Check = 1'b0;
    endtask

    initial begin
        bit done, hs_ok, quiet, saw;
        int lat;
        int model_fc;
        logic [31:0] id, pw;
        int gm;
        bit exp_g;

        Reset = 1'b0; Check = 1'b0; WordValid = 1'b0; WordIn = '0;
        UserID = '0; UserPass = '0;
        load_fixed_rom();
        repeat (2) @(negedge Clk);
        chk("reset_outputs", {Start, Busy, Done, Granted, Denied, TimedOut, Locked, FailCount}, '0);
        Reset = 1'b1;
        @(negedge Clk);

        // id, pw, gap_max, n_words, Granted, Denied, TimedOut, Locked, FailCount, latency
        vecs[0] = '{32'h0000_1234, 32'hCAFE_F00D, 0, 32, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 34};
        vecs[1] = '{32'h0000_1234, 32'hCAFE_F00E, 0, 32, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 34};
        vecs[2] = '{32'hAAAA_0002, 32'h3333_3333, 0, 32, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 34};
        vecs[3] = '{32'hF00D_000F, 32'hFFFF_000F, 0, 32, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 34};
        vecs[4] = '{32'h0000_0000, 32'h7777_7777, 0, 32, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 34};
        vecs[5] = '{32'h0000_1234, 32'hCAFE_F00D, 5, 32, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, -1};
        // Word 10 at cycle 12, 64 idle cycles 13..76 -> Done at cycle 77.
        vecs[6] = '{32'h0000_1234, 32'hCAFE_F00D, 0, 11, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 77};
        vecs[7] = '{32'h0100_0003, 32'h0000_0000, 0, 32, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 34};
        vecs[8] = '{32'hBBBB_0003, 32'h2222_2222, 2, 32, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3, -1};

        for (int i = 0; i < 9; i++) begin
            do_check(vecs[i].id, vecs[i].pw, vecs[i].gap_max, vecs[i].n_words, -1, 1'b0,
                     done, lat, hs_ok);
            chk($sformatf("v%0d_done", i), 64'(done), 64'd1);
            chk($sformatf("v%0d_result", i), {Granted, Denied, TimedOut, Locked, FailCount},
                {vecs[i].g, vecs[i].d, vecs[i].t, vecs[i].l, vecs[i].fc});
            chk($sformatf("v%0d_handshake", i), 64'(hs_ok), 64'd1);
            if (vecs[i].lat >= 0) chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
            // Late / stray words must neither restart nor disturb the result.
            quiet = 1'b1;
            repeat (3) begin
                WordValid = 1'b1; WordIn = rom[1];
                @(negedge Clk);
                if (Busy !== 1'b0 || Done !== 1'b0 || Start !== 1'b0) quiet = 1'b0;
            end
            WordValid = 1'b0;
            chk($sformatf("v%0d_quiet_after", i), 64'(quiet), 64'd1);
            chk($sformatf("v%0d_held", i), {Granted, Denied, TimedOut, Locked, FailCount},
                {vecs[i].g, vecs[i].d, vecs[i].t, vecs[i].l, vecs[i].fc});
        end

        // Locked: a further Check produces no Start.
        Check = 1'b1; UserID = 32'h0000_1234; UserPass = 32'hCAFE_F00D;
        saw = 1'b0;
        repeat (6) begin
            @(negedge Clk);
            if (Start !== 1'b0 || Busy !== 1'b0) saw = 1'b1;
        end
        Check = 1'b0;
        chk("locked_no_start", 64'(saw), 64'd0);
        chk("locked_hold", {Locked, FailCount, Denied}, {1'b1, 2'd3, 1'b1});
        Reset = 1'b0;
        #1;
        chk("reset_clears_lock", {Locked, FailCount, Denied}, '0);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);

        // Mid-stream reset: one failure first so FailCount is non-zero.
        do_check(32'h0000_1234, 32'h0000_0000, 0, 32, -1, 1'b0, done, lat, hs_ok);
        chk("pre_abort_fc", 64'(FailCount), 64'd1);
        do_check(32'h0000_1234, 32'hCAFE_F00D, 0, 32, 17, 1'b0, done, lat, hs_ok);
        chk("abort_no_done", 64'(done), 64'd0);
        chk("abort_outputs", {Start, Busy, Done, Granted, Denied, TimedOut, Locked, FailCount}, '0);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        chk("abort_idle", {Start, Busy, Done, FailCount}, '0);
        do_check(32'h0000_1234, 32'hCAFE_F00D, 0, 32, -1, 1'b0, done, lat, hs_ok);
        chk("post_abort_result", {done, Granted, Denied, FailCount}, {1'b1, 1'b1, 1'b0, 2'd0});
        chk("post_abort_latency", 64'(lat), 64'd34);

        // Check held high across Done: new Start two cycles after Done.
        do_check(32'h0000_1234, 32'hCAFE_F00D, 0, 32, -1, 1'b1, done, lat, hs_ok);
        chk("held_first_done", {done, Granted}, {1'b1, 1'b1});
        @(negedge Clk);
        chk("held_idle_cycle", {Start, Busy}, '0);
        @(negedge Clk);
        chk("held_restart", {Start, Busy, Granted}, {1'b1, 1'b1, 1'b0});
        Check = 1'b0;
        do_reset();

        // Randomized ROM images and entries.
        model_fc = 0;
        for (int it = 0; it < 24; it++) begin
            for (int k = 0; k < 16; k++) begin
                rom[2*k]   = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'h100 + $urandom_range(0, 11);
                rom[2*k+1] = $urandom_range(0, 3);
            end
            begin
                int k1, k2;
                k1 = $urandom_range(0, 15);
                k2 = $urandom_range(0, 15);
                id = ($urandom_range(0, 5) == 0) ? 32'h100 + $urandom_range(0, 11) : rom[2*k1];
                pw = ($urandom_range(0, 1) == 0) ? rom[2*k1+1] : rom[2*k2+1];
            end
            gm = $urandom_range(0, 3);
            exp_g = model_grant(id, pw);
            model_fc = exp_g ? 0 : ((model_fc == 3) ? 3 : model_fc + 1);
            do_check(id, pw, gm, 32, -1, 1'b0, done, lat, hs_ok);
            chk($sformatf("r%0d_result", it), {done, Granted, Denied, TimedOut, Locked, FailCount},
                {1'b1, exp_g, !exp_g, 1'b0, (model_fc == 3), 2'(model_fc)});
            chk($sformatf("r%0d_handshake", it), 64'(hs_ok), 64'd1);
            if (gm == 0) chk($sformatf("r%0d_latency", it), 64'(lat), 64'd34);
            if (model_fc == 3) begin
                do_reset();
                model_fc = 0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
